// File: rtl/ts_burst_gate_pkg.sv
// ts_burst_gate_pkg: shared state encoding, default widths and stat word layout for the burst gate
package ts_burst_gate_pkg;
  localparam int DEF_LEN_BITS = 16;
  localparam int DEF_GUARD_BITS = 8;
  localparam int STAT_W = 16;
  localparam int STAT_BURST_LSB = 0;
  localparam int STAT_ABORT_LSB = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACT  = 2'd2,
    POST = 2'd3
  } state_t;
  function automatic logic [31:0] pack_stats(input logic [STAT_W-1:0] aborts, input logic [STAT_W-1:0] bursts);
    logic [31:0] s;
    s = '0;
    s[STAT_ABORT_LSB +: STAT_W] = aborts;
    s[STAT_BURST_LSB +: STAT_W] = bursts;
    return s;
  endfunction
endpackage

// File: rtl/ts_burst_gate_if.sv
// ts_burst_gate_if: command handshake, gate enables and statistics between scheduler and burst gate
interface ts_burst_gate_if;
  logic cmd_valid;
  logic cmd_ready;
  logic abort;
  logic gate_pa;
  logic gate_data;
  logic busy;
  logic done;
  logic stat_valid;
  logic [31:0] stat_data;
  modport master (
    output cmd_valid, abort,
    input  cmd_ready, gate_pa, gate_data, busy, done, stat_valid, stat_data
  );
  modport slave (
    input  cmd_valid, abort,
    output cmd_ready, gate_pa, gate_data, busy, done, stat_valid, stat_data
  );
endinterface

// File: rtl/ts_burst_gate_cnt.sv
// ts_burst_gate_cnt: loadable down-counter (loads value-1, holds at zero) with terminal-count flag
module ts_burst_gate_cnt #(
  parameter int W = 8
) (
  input  logic         ts_clk,
  input  logic         ts_reset_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge ts_clk or negedge ts_reset_n)
    if (!ts_reset_n) cnt <= '0;
    else if (load) cnt <= (val == '0) ? '0 : val - W'(1);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/ts_burst_gate.sv
// ts_burst_gate: guard/burst/guard PA window with inner data window, started by a scheduler command.
// Optional statistics counters under TS_BURST_GATE_STATS_EN.
module ts_burst_gate
  import ts_burst_gate_pkg::*;
#(
  parameter int LEN_BITS   = DEF_LEN_BITS,
  parameter int GUARD_BITS = DEF_GUARD_BITS
) (
  input logic                  ts_clk,
  input logic                  ts_reset_n,
  input logic                  cfg_enable,
  input logic [LEN_BITS-1:0]   cfg_len,
  input logic [GUARD_BITS-1:0] cfg_guard,
  ts_burst_gate_if.slave       bus
);
  state_t state, nxt;
  logic [LEN_BITS-1:0] len_q;
  logic [GUARD_BITS-1:0] guard_q;
  logic fire, aborting, ending, g_tc, l_tc;
  assign bus.cmd_ready = (state == IDLE) & cfg_enable;
  assign fire = bus.cmd_valid & bus.cmd_ready;
  assign aborting = bus.abort & (state == PRE | state == ACT);
  // every exit from PRE/ACT reloads the guard counter so POST always gets the full lead-out
  assign ending = aborting | (state == PRE & g_tc) | (state == ACT & l_tc);
  ts_burst_gate_cnt #(.W(GUARD_BITS)) u_guard (
    .ts_clk, .ts_reset_n,
    .load (fire | ending),
    .val  (fire ? cfg_guard : guard_q),
    .en   (state == PRE | state == POST),
    .tc   (g_tc)
  );
  ts_burst_gate_cnt #(.W(LEN_BITS)) u_len (
    .ts_clk, .ts_reset_n,
    .load (fire | (state == PRE & g_tc)),
    .val  (fire ? cfg_len : len_q),
    .en   (state == ACT),
    .tc   (l_tc)
  );
  always_comb
    case (state)
      IDLE:    nxt = !fire ? IDLE : cfg_guard != '0 ? PRE : cfg_len != '0 ? ACT : IDLE;
      PRE:     nxt = (bus.abort | (g_tc & (len_q == '0))) ? POST : g_tc ? ACT : PRE;
      ACT:     nxt = !(bus.abort | l_tc) ? ACT : guard_q != '0 ? POST : IDLE;
      default: nxt = g_tc ? IDLE : POST;
    endcase
  always_ff @(posedge ts_clk or negedge ts_reset_n)
    if (!ts_reset_n) begin
      state         <= IDLE;
      len_q         <= '0;
      guard_q       <= '0;
      bus.gate_pa   <= 1'b0;
      bus.gate_data <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state <= nxt;
      if (fire) begin
        len_q   <= cfg_len;
        guard_q <= cfg_guard;
      end
      bus.gate_pa   <= nxt != IDLE;
      bus.gate_data <= nxt == ACT;
      bus.busy      <= nxt != IDLE;
      bus.done      <= (state != IDLE | fire) & nxt == IDLE;
    end
`ifdef TS_BURST_GATE_STATS_EN
  logic [STAT_W-1:0] bursts, aborts;
  always_ff @(posedge ts_clk or negedge ts_reset_n)
    if (!ts_reset_n) begin
      bursts <= '0;
      aborts <= '0;
    end else begin
      if (fire) bursts <= bursts + STAT_W'(1);
      if (aborting) aborts <= aborts + STAT_W'(1);
    end
  assign bus.stat_valid = 1'b1;
  assign bus.stat_data  = pack_stats(aborts, bursts);
`else
  assign bus.stat_valid = 1'b0;
  assign bus.stat_data  = '0;
`endif
endmodule

// File: tb/tb_ts_burst_gate.sv
// tb_ts_burst_gate: table-driven burst timing vectors plus handshake, enable and reset sequences
module tb_ts_burst_gate;
  logic ts_clk = 1'b0;
  logic ts_reset_n = 1'b0;
  logic cfg_enable = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0] cfg_guard = '0;
  ts_burst_gate_if bus();
  ts_burst_gate dut (
    .ts_clk     (ts_clk),
    .ts_reset_n (ts_reset_n),
    .cfg_enable (cfg_enable),
    .cfg_len    (cfg_len),
    .cfg_guard  (cfg_guard),
    .bus        (bus)
  );
  always #5 ts_clk = ~ts_clk;
  int checks = 0;
  int errors = 0;
  int exp_bursts = 0;
  int exp_aborts = 0;
  typedef struct {
    int guard;
    int len;
    int abort_at;
    int pa_first;
    int pa_cnt;
    int data_first;
    int data_cnt;
    int done_at;
    int aborts;
  } vec_t;
  vec_t vecs[7];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic check_stats(input string name);
`ifdef TS_BURST_GATE_STATS_EN
    check({name, "_stat_valid"}, 32'(bus.stat_valid), 32'd1);
    check({name, "_stat_data"}, bus.stat_data, 32'((exp_aborts << 16) | exp_bursts));
`else
    check({name, "_stat_valid"}, 32'(bus.stat_valid), 32'd0);
    check({name, "_stat_data"}, bus.stat_data, 32'd0);
`endif
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int pa_first, pa_cnt, data_first, data_cnt, done_at;
    pa_first = 0; pa_cnt = 0; data_first = 0; data_cnt = 0; done_at = 0;
    cfg_guard = 8'(v.guard);
    cfg_len = 16'(v.len);
    bus.cmd_valid = 1'b1;
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge ts_clk);
    #1;
    bus.cmd_valid = 1'b0;
    cfg_guard = 8'd9;
    cfg_len = 16'd7;
    for (int k = 1; k <= 150 && done_at == 0; k++) begin
      @(negedge ts_clk);
      if (bus.gate_pa) begin
        pa_cnt++;
        if (pa_first == 0) pa_first = k;
      end
      if (bus.gate_data) begin
        data_cnt++;
        if (data_first == 0) data_first = k;
      end
      if (bus.done) done_at = k;
      bus.abort = v.abort_at != 0 && data_cnt == v.abort_at && bus.gate_data;
    end
    bus.abort = 1'b0;
    exp_bursts++;
    exp_aborts += v.aborts;
    check({tag, "_pa_first"}, pa_first, v.pa_first);
    check({tag, "_pa_cnt"}, pa_cnt, v.pa_cnt);
    check({tag, "_data_first"}, data_first, v.data_first);
    check({tag, "_data_cnt"}, data_cnt, v.data_cnt);
    check({tag, "_done_at"}, done_at, v.done_at);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
    check_stats(tag);
    @(negedge ts_clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    int fires[$];
    int dones[$];
    int exp_ev[5];
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    vecs[0] = '{4, 10, 0, 1, 18, 5, 10, 19, 0};
    vecs[1] = '{0, 3, 0, 1, 3, 1, 3, 4, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{2, 100, 5, 1, 9, 3, 5, 10, 1};
    vecs[4] = '{3, 0, 0, 1, 6, 0, 0, 7, 0};
    vecs[5] = '{1, 1, 1, 1, 3, 2, 1, 4, 1};
    vecs[6] = '{0, 5, 2, 1, 2, 1, 2, 3, 1};
    #2;
    check("rst_ready_disabled", 32'(bus.cmd_ready), 32'd0);
    cfg_enable = 1'b1;
    #1;
    check("rst_ready_enabled", 32'(bus.cmd_ready), 32'd1);
    check("rst_pa", 32'(bus.gate_pa), 32'd0);
    check("rst_data", 32'(bus.gate_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_stats("rst");
    @(negedge ts_clk);
    ts_reset_n = 1'b1;
    @(negedge ts_clk);
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
    cfg_guard = 8'd1;
    cfg_len = 16'd2;
    bus.cmd_valid = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge ts_clk);
      if (bus.cmd_valid && bus.cmd_ready) fires.push_back(n);
      if (bus.done) dones.push_back(n);
      if (n == 22) cfg_enable = 1'b0;
    end
    exp_ev = '{0, 5, 10, 15, 20};
    check("cont_fire_count", fires.size(), 32'd5);
    check("cont_done_count", dones.size(), 32'd5);
    for (int i = 0; i < 5 && i < fires.size(); i++) check($sformatf("cont_fire%0d", i), fires[i], exp_ev[i]);
    for (int i = 0; i < 5 && i < dones.size(); i++) check($sformatf("cont_done%0d", i), dones[i], exp_ev[i] + 5);
    check("cont_idle_busy", 32'(bus.busy), 32'd0);
    check("cont_ready_disabled", 32'(bus.cmd_ready), 32'd0);
    exp_bursts += 5;
    check_stats("cont");
    bus.cmd_valid = 1'b0;
    cfg_enable = 1'b1;
    cfg_guard = 8'd2;
    cfg_len = 16'd10;
    @(negedge ts_clk);
    bus.cmd_valid = 1'b1;
    @(posedge ts_clk);
    #1;
    bus.cmd_valid = 1'b0;
    exp_bursts++;
    repeat (4) @(negedge ts_clk);
    check("mid_act_data", 32'(bus.gate_data), 32'd1);
    check_stats("mid_act");
    ts_reset_n = 1'b0;
    #1;
    exp_bursts = 0;
    exp_aborts = 0;
    check("arst_pa", 32'(bus.gate_pa), 32'd0);
    check("arst_data", 32'(bus.gate_data), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check_stats("arst");
    @(negedge ts_clk);
    ts_reset_n = 1'b1;
    @(negedge ts_clk);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst_pa", 32'(bus.gate_pa), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
